// File: rtl/usb_crc_engine.sv
// Bit-serial CRC engine for the USB SIE: accumulates packet bits, checks the
// receive residue and serialises the inverted CRC MSB first on transmit.
module usb_crc_engine #(
   parameter int unsigned      WIDTH   = 16,
   parameter logic [WIDTH-1:0] POLY    = 16'h8005,
   parameter logic [WIDTH-1:0] INIT    = 16'hFFFF,
   parameter logic [WIDTH-1:0] RESIDUE = 16'h800D
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             data,
   input  logic             data_valid,
   input  logic             finish,
   output logic             crc_bit,
   output logic             crc_bit_valid,
   input  logic             crc_ready,
   output logic             crc_last,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic             residue_ok
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      EMIT
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] crc, crc_n;
   logic [CW-1:0]    count, count_n;
   logic             fb;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         crc   <= INIT;
         count <= '0;
      end else begin
         state <= state_n;
         crc   <= crc_n;
         count <= count_n;
      end
   end

   assign fb = data ^ crc[WIDTH-1];

   always_comb begin
      state_n = state;
      crc_n   = crc;
      count_n = count;
      if (start) begin
         state_n = ACCUM;
         crc_n   = INIT;
         count_n = '0;
      end else begin
         unique case (state)
            ACCUM: begin
               // a bit arriving with finish is folded in before emission
               if (data_valid)
                  crc_n = {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
               if (finish)
                  state_n = EMIT;
            end
            EMIT: begin
               // shifting in ones leaves the register all-ones when done
               if (crc_ready) begin
                  crc_n   = {crc[WIDTH-2:0], 1'b1};
                  count_n = count + CW'(1);
                  if (count == LAST)
                     state_n = IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy          = (state != IDLE);
   assign crc_bit_valid = (state == EMIT);
   assign crc_bit       = ~crc[WIDTH-1];
   assign crc_last      = (state == EMIT) && (count == LAST);
   assign result        = crc;
   assign residue_ok    = (crc == RESIDUE);

endmodule

// File: tb/tb_usb_crc_engine.sv
// Scoreboard bench for usb_crc_engine: CRC16 and CRC5 transmitters looped
// back into receiver instances, with bit-stream and register probes.
module tb_usb_crc_engine;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start16, data16, dv16, fin16, rdy16, flip16;
   logic        tx16_bit, tx16_valid, tx16_last, tx16_busy, tx16_rok;
   logic [15:0] tx16_res;
   logic        rx16_d, rx16_dv;
   logic        rx16_bit, rx16_valid, rx16_last, rx16_busy, rx16_rok;
   logic [15:0] rx16_res;

   logic        start5, data5, dv5, fin5, rdy5;
   logic        c5_bit, c5_valid, c5_last, c5_busy, c5_rok;
   logic [4:0]  c5_res;
   logic        r5_d, r5_dv;
   logic        r5_bit, r5_valid, r5_last, r5_busy, r5_rok;
   logic [4:0]  r5_res;

   assign rx16_d  = (tx16_valid ? tx16_bit : data16) ^ flip16;
   assign rx16_dv = tx16_valid ? rdy16 : dv16;
   assign r5_d    = c5_valid ? c5_bit : data5;
   assign r5_dv   = c5_valid ? rdy5 : dv5;

   usb_crc_engine tx16 (
      .clk(clk), .rst(rst), .start(start16), .data(data16),
      .data_valid(dv16), .finish(fin16), .crc_bit(tx16_bit),
      .crc_bit_valid(tx16_valid), .crc_ready(rdy16),
      .crc_last(tx16_last), .busy(tx16_busy), .result(tx16_res),
      .residue_ok(tx16_rok)
   );

   usb_crc_engine rx16 (
      .clk(clk), .rst(rst), .start(start16), .data(rx16_d),
      .data_valid(rx16_dv), .finish(1'b0), .crc_bit(rx16_bit),
      .crc_bit_valid(rx16_valid), .crc_ready(1'b0),
      .crc_last(rx16_last), .busy(rx16_busy), .result(rx16_res),
      .residue_ok(rx16_rok)
   );

   usb_crc_engine #(
      .WIDTH(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUE(5'h0C)
   ) c5 (
      .clk(clk), .rst(rst), .start(start5), .data(data5),
      .data_valid(dv5), .finish(fin5), .crc_bit(c5_bit),
      .crc_bit_valid(c5_valid), .crc_ready(rdy5),
      .crc_last(c5_last), .busy(c5_busy), .result(c5_res),
      .residue_ok(c5_rok)
   );

   usb_crc_engine #(
      .WIDTH(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUE(5'h0C)
   ) r5 (
      .clk(clk), .rst(rst), .start(start5), .data(r5_d),
      .data_valid(r5_dv), .finish(1'b0), .crc_bit(r5_bit),
      .crc_bit_valid(r5_valid), .crc_ready(1'b0),
      .crc_last(r5_last), .busy(r5_busy), .result(r5_res),
      .residue_ok(r5_rok)
   );

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } probe_t;

   probe_t     pq[$];
   logic [1:0] q16[$];
   logic [1:0] q5[$];
   logic       pl[$];
   int         total = 0;
   int         passed = 0;

   task automatic cmp(input string n, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", n, got, exp);
   endtask

   task automatic want(input string n, input int sel, input logic [31:0] exp);
      probe_t p;
      p.name = n;
      p.sel  = sel;
      p.exp  = exp;
      pq.push_back(p);
   endtask

   function automatic logic [31:0] probe_val(input int sel);
      case (sel)
         0: return 32'(tx16_res);
         1: return 32'(rx16_res);
         2: return 32'(rx16_rok);
         3: return 32'(tx16_busy);
         4: return 32'(tx16_valid);
         5: return 32'(tx16_last);
         6: return 32'(c5_res);
         default: return 32'(r5_rok);
      endcase
   endfunction

   probe_t     mp;
   logic [1:0] me;
   logic       hold16 = 1'b0, hold5 = 1'b0;
   logic [1:0] held16, held5;

   // monitor: probes, accepted CRC bits and stability under backpressure
   always @(negedge clk) begin
      while (pq.size() > 0) begin
         mp = pq.pop_front();
         cmp(mp.name, probe_val(mp.sel), mp.exp);
      end
      if (hold16 && tx16_valid)
         cmp("stable16", 32'({tx16_bit, tx16_last}), 32'(held16));
      hold16 = tx16_valid && !rdy16;
      held16 = {tx16_bit, tx16_last};
      if (tx16_valid && rdy16) begin
         if (q16.size() == 0) cmp("bit16_unexpected", 32'(q16.size()), 1);
         else begin
            me = q16.pop_front();
            cmp("bit16", 32'({tx16_bit, tx16_last}), 32'(me));
         end
      end
      if (hold5 && c5_valid)
         cmp("stable5", 32'({c5_bit, c5_last}), 32'(held5));
      hold5 = c5_valid && !rdy5;
      held5 = {c5_bit, c5_last};
      if (c5_valid && rdy5) begin
         if (q5.size() == 0) cmp("bit5_unexpected", 32'(q5.size()), 1);
         else begin
            me = q5.pop_front();
            cmp("bit5", 32'({c5_bit, c5_last}), 32'(me));
         end
      end
   end

   function automatic logic [31:0] calc(input int w, input logic [31:0] poly,
                                        input logic [31:0] init, input int n);
      logic [31:0] c, m;
      logic        fb;
      m = (32'h1 << w) - 32'h1;
      c = init;
      for (int i = 0; i < n; i++) begin
         fb = pl[i] ^ c[w-1];
         c  = (c << 1) & m;
         if (fb) c = c ^ poly;
      end
      return c;
   endfunction

   task automatic push_bits(input bit is16, input int nmax);
      logic [31:0] c;
      int          w;
      w = is16 ? 16 : 5;
      c = is16 ? calc(16, 32'h8005, 32'hFFFF, pl.size())
               : calc(5, 32'h05, 32'h1F, pl.size());
      for (int i = 0; i < nmax; i++) begin
         if (is16) q16.push_back({~c[w-1-i], i == w - 1});
         else q5.push_back({~c[w-1-i], i == w - 1});
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic feed16(input int flip_at, input bit fin);
      start16 = 1'b1;
      tick;
      start16 = 1'b0;
      for (int i = 0; i < pl.size(); i++) begin
         data16 = pl[i];
         dv16   = 1'b1;
         flip16 = (i == flip_at);
         fin16  = fin && (i == pl.size() - 1);
         tick;
      end
      dv16   = 1'b0;
      fin16  = 1'b0;
      flip16 = 1'b0;
   endtask

   task automatic emit16(input bit rnd, input int flip_at, output int cyc);
      cyc = 0;
      while (tx16_busy && cyc < 400) begin
         rdy16  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         flip16 = (cyc == flip_at);
         tick;
         cyc++;
      end
      rdy16  = 1'b0;
      flip16 = 1'b0;
      want("emit16_done", 3, 0);
   endtask

   task automatic run5;
      int cyc;
      push_bits(1'b0, 5);
      start5 = 1'b1;
      tick;
      start5 = 1'b0;
      for (int i = 0; i < pl.size(); i++) begin
         data5 = pl[i];
         dv5   = 1'b1;
         fin5  = (i == pl.size() - 1);
         tick;
      end
      dv5  = 1'b0;
      fin5 = 1'b0;
      cyc  = 0;
      while (c5_busy && cyc < 100) begin
         rdy5 = 1'($urandom_range(0, 1));
         tick;
         cyc++;
      end
      rdy5 = 1'b0;
      want("crc5_residue_ok", 7, 1);
      want("crc5_tx_result", 6, 32'h1F);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          cyc;
      logic [31:0] pre;
      logic [7:0]  b;
      logic [10:0] tok;
      rst = 1'b1;
      {start16, data16, dv16, fin16, rdy16, flip16} = '0;
      {start5, data5, dv5, fin5, rdy5} = '0;
      repeat (2) tick;
      rst = 1'b0;
      want("rst_result", 0, 32'hFFFF);
      want("rst_busy", 3, 0);
      want("rst_valid", 4, 0);
      want("rst_last", 5, 0);
      want("rst_residue16", 2, 0);
      want("rst_result5", 6, 32'h1F);
      want("rst_residue5", 7, 0);
      tick;

      start16 = 1'b1;
      tick;
      start16 = 1'b0; data16 = 1'b1; dv16 = 1'b1;
      tick;
      dv16 = 1'b0;
      want("single_one", 0, 32'hFFFE);
      start16 = 1'b1;
      tick;
      start16 = 1'b0; data16 = 1'b0; dv16 = 1'b1;
      tick;
      dv16 = 1'b0;
      want("single_zero", 0, 32'h7FFB);
      start16 = 1'b1; dv16 = 1'b1; data16 = 1'b1;
      tick;
      start16 = 1'b0; dv16 = 1'b0;
      want("start_dv_ignored", 0, 32'hFFFF);

      start5 = 1'b1;
      tick;
      start5 = 1'b0; data5 = 1'b1; dv5 = 1'b1;
      tick;
      dv5 = 1'b0;
      want("crc5_single_one", 6, 32'h1E);

      // zero-length DATA packet
      for (int i = 0; i < 16; i++) q16.push_back({1'b0, i == 15});
      start16 = 1'b1;
      tick;
      start16 = 1'b0; fin16 = 1'b1;
      tick;
      fin16 = 1'b0;
      emit16(1'b0, -1, cyc);
      cmp("zlp_cycles", cyc, 16);
      want("zlp_result", 0, 32'hFFFF);

      pl.delete();
      for (int i = 0; i < 64; i++) begin
         b = 8'($urandom);
         for (int j = 0; j < 8; j++) pl.push_back(b[j]);
      end
      push_bits(1'b1, 16);
      feed16(-1, 1'b1);
      emit16(1'b0, -1, cyc);
      cmp("loop_cycles", cyc, 16);
      want("loop_rx_result", 1, 32'h800D);
      want("loop_residue_ok", 2, 1);
      want("loop_tx_result", 0, 32'hFFFF);

      push_bits(1'b1, 16);
      feed16(37, 1'b1);
      emit16(1'b0, -1, cyc);
      want("flip_payload_residue", 2, 0);

      push_bits(1'b1, 16);
      feed16(-1, 1'b1);
      emit16(1'b0, 5, cyc);
      want("flip_crc_residue", 2, 0);

      push_bits(1'b1, 16);
      feed16(-1, 1'b1);
      emit16(1'b1, -1, cyc);
      want("bp_residue_ok", 2, 1);
      want("bp_rx_result", 1, 32'h800D);

      // abort an emission after five accepted bits
      pl.delete();
      b = 8'hA5;
      for (int j = 0; j < 8; j++) pl.push_back(b[j]);
      push_bits(1'b1, 5);
      feed16(-1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         rdy16 = 1'b1;
         tick;
      end
      rdy16 = 1'b0; start16 = 1'b1;
      tick;
      start16 = 1'b0;
      want("abort_valid", 4, 0);
      want("abort_result", 0, 32'hFFFF);
      want("abort_busy", 3, 1);
      @(negedge clk);
      #1;
      cmp("abort_bits_left", 32'(q16.size()), 0);

      pre = calc(16, 32'h8005, 32'hFFFF, pl.size());
      feed16(-1, 1'b0);
      want("accum_before_rst", 0, pre);
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      want("rst_mid_result", 0, 32'hFFFF);
      want("rst_mid_busy", 3, 0);
      want("rst_mid_valid", 4, 0);
      want("rst_mid_last", 5, 0);
      tick;

      for (int t = 0; t < 3; t++) begin
         tok = 11'($urandom);
         pl.delete();
         for (int j = 0; j < 11; j++) pl.push_back(tok[j]);
         run5();
         tick;
      end

      repeat (2) tick;
      cmp("bits16_left", 32'(q16.size()), 0);
      cmp("bits5_left", 32'(q5.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
